serial_compare_driver: RTL and testbench

- Upstream feeder for the bit-serial magnitude comparator.
- Accepts two WIDTH-bit unsigned operands over a valid/ready handshake and clears the comparator.
- Shifts both operands into it MSB-first, one bit per clock, then captures its greater/less flags.
- Returns a registered greater/less/equal result over a second valid/ready handshake.

---
 rtl/serial_compare_driver_if.sv | 48 ++++
 rtl/serial_compare_driver.sv | 154 +++++++++++++++
 tb/tb_serial_compare_driver.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_compare_driver_if.sv
// Handshake bundle between the serial comparator driver and its client.
//
// Start channel : start_valid / start_ready carry one operand pair (a, b).
// Result channel: result_valid / result_ready carry greater/less/equal/conflict.
//
// Modports:
//   master - the client: drives operands and result_ready, observes the rest.
//   slave  - the driver block: accepts operands and returns the result.
interface serial_compare_driver_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             result_valid;
    logic             result_ready;
    logic             greater;
    logic             less;
    logic             equal;
    logic             conflict;

    modport master (
        output start_valid,
        output a,
        output b,
        output result_ready,
        input  start_ready,
        input  result_valid,
        input  greater,
        input  less,
        input  equal,
        input  conflict
    );

    modport slave (
        input  start_valid,
        input  a,
        input  b,
        input  result_ready,
        output start_ready,
        output result_valid,
        output greater,
        output less,
        output equal,
        output conflict
    );
endinterface

// File: rtl/serial_compare_driver.sv
// Upstream feeder for a bit-serial magnitude comparator.
//
// Accepts an operand pair on the start channel, clears the comparator for one
// cycle, shifts both operands into it MSB-first (one bit per clock), lets it
// settle for one cycle, then returns its greater/less flags as a registered
// result on the result channel.
//
// Ports:
//   clk        - system clock, rising edge.
//   reset      - synchronous active-low reset.
//   bus        - start/result handshakes (slave side of serial_compare_driver_if).
//   x_bit      - serial bit of operand a to the comparator x input.
//   y_bit      - serial bit of operand b to the comparator y input.
//   cmp_reset  - active-high clear to the comparator.
//   cmp_gt     - comparator greater-than flag.
//   cmp_lt     - comparator less-than flag.
module serial_compare_driver #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    serial_compare_driver_if.slave  bus,
    output logic                    x_bit,
    output logic                    y_bit,
    output logic                    cmp_reset,
    input  logic                    cmp_gt,
    input  logic                    cmp_lt
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StShift,
        StSettle,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic start_ready_q, start_ready_d;
    logic cmp_reset_q, cmp_reset_d;
    logic x_bit_q, x_bit_d;
    logic y_bit_q, y_bit_d;
    logic result_valid_q, result_valid_d;
    logic greater_q, greater_d;
    logic less_q, less_d;
    logic equal_q, equal_d;
    logic conflict_q, conflict_d;

    always_comb begin
        state_d    = state_q;
        sh_a_d     = sh_a_q;
        sh_b_d     = sh_b_q;
        cnt_d      = cnt_q;
        greater_d  = greater_q;
        less_d     = less_q;
        equal_d    = equal_q;
        conflict_d = conflict_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start_valid && start_ready_q) begin
                    sh_a_d  = bus.a;
                    sh_b_d  = bus.b;
                    cnt_d   = CntW'(WIDTH);
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = StShift;
            end
            StShift: begin
                sh_a_d = sh_a_q << 1;
                sh_b_d = sh_b_q << 1;
                cnt_d  = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                greater_d  = cmp_gt;
                less_d     = cmp_lt;
                equal_d    = ~cmp_gt & ~cmp_lt;
                conflict_d = cmp_gt & cmp_lt;
                state_d    = StDone;
            end
            StDone: begin
                if (bus.result_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state and
        // the next shift-register contents: the MSB of sh_*_d is exactly the
        // bit that must be on the wire during the upcoming SHIFT cycle.
        start_ready_d  = (state_d == StIdle);
        cmp_reset_d    = (state_d == StIdle) || (state_d == StClear);
        x_bit_d        = (state_d == StShift) && sh_a_d[WIDTH-1];
        y_bit_d        = (state_d == StShift) && sh_b_d[WIDTH-1];
        result_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= StIdle;
            sh_a_q         <= '0;
            sh_b_q         <= '0;
            cnt_q          <= '0;
            start_ready_q  <= 1'b1;
            cmp_reset_q    <= 1'b1;
            x_bit_q        <= 1'b0;
            y_bit_q        <= 1'b0;
            result_valid_q <= 1'b0;
            greater_q      <= 1'b0;
            less_q         <= 1'b0;
            equal_q        <= 1'b0;
            conflict_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            sh_a_q         <= sh_a_d;
            sh_b_q         <= sh_b_d;
            cnt_q          <= cnt_d;
            start_ready_q  <= start_ready_d;
            cmp_reset_q    <= cmp_reset_d;
            x_bit_q        <= x_bit_d;
            y_bit_q        <= y_bit_d;
            result_valid_q <= result_valid_d;
            greater_q      <= greater_d;
            less_q         <= less_d;
            equal_q        <= equal_d;
            conflict_q     <= conflict_d;
        end
    end

    assign bus.start_ready  = start_ready_q;
    assign bus.result_valid = result_valid_q;
    assign bus.greater      = greater_q;
    assign bus.less         = less_q;
    assign bus.equal        = equal_q;
    assign bus.conflict     = conflict_q;
    assign x_bit            = x_bit_q;
    assign y_bit            = y_bit_q;
    assign cmp_reset        = cmp_reset_q;

endmodule

// File: tb/tb_serial_compare_driver.sv
// Bench for serial_compare_driver: behavioural comparator stub, elapsed-time
// reference model, per-cycle output compare plus directed literal checks.
module tb_serial_compare_driver;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_compare_driver_if #(.WIDTH(W)) bus ();

    logic x_bit, y_bit, cmp_reset, cmp_gt, cmp_lt;

    serial_compare_driver #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .x_bit     (x_bit),
        .y_bit     (y_bit),
        .cmp_reset (cmp_reset),
        .cmp_gt    (cmp_gt),
        .cmp_lt    (cmp_lt)
    );

    // Bit-serial MSB-first comparator: first differing bit decides, then holds.
    logic st_gt, st_lt, fault;
    always @(posedge clk) begin
        if (cmp_reset) begin
            st_gt <= 1'b0;
            st_lt <= 1'b0;
        end else if (!st_gt && !st_lt) begin
            st_gt <= x_bit & ~y_bit;
            st_lt <= ~x_bit & y_bit;
        end
    end
    assign cmp_gt = st_gt | fault;
    assign cmp_lt = st_lt | fault;

    // Reference model: m_t counts cycles since the accept edge.
    // t=1 clear, t=2..W+1 shift, t=W+2 settle, t=W+3 result pending.
    int           cyc = 0;
    logic         check_en = 1'b0;
    logic         m_busy;
    int           m_t;
    logic [W-1:0] m_a, m_b;
    logic         m_g, m_l, m_e, m_c;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            check_en <= 1'b1;
            m_busy   <= 1'b0;
            m_t      <= 0;
            m_g      <= 1'b0;
            m_l      <= 1'b0;
            m_e      <= 1'b0;
            m_c      <= 1'b0;
        end else if (!m_busy) begin
            if (bus.start_valid) begin
                m_busy <= 1'b1;
                m_t    <= 1;
                m_a    <= bus.a;
                m_b    <= bus.b;
            end
        end else if (m_t < W + 3) begin
            m_t <= m_t + 1;
            if (m_t == W + 2) begin
                if (fault) begin
                    m_g <= 1'b1;
                    m_l <= 1'b1;
                    m_e <= 1'b0;
                    m_c <= 1'b1;
                end else begin
                    m_g <= (m_a > m_b);
                    m_l <= (m_a < m_b);
                    m_e <= (m_a == m_b);
                    m_c <= 1'b0;
                end
            end
        end else if (bus.result_ready) begin
            m_busy <= 1'b0;
        end
    end

    int   n_total = 0;
    int   n_pass  = 0;
    logic rr_rand = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [8:0] dut_vec();
        return {bus.start_ready, cmp_reset, x_bit, y_bit, bus.result_valid,
                bus.greater, bus.less, bus.equal, bus.conflict};
    endfunction

    // Advance one clock; sample 1 time unit after the edge and compare to model.
    task automatic step();
        logic       ex, ey, in_shift;
        logic [8:0] exp;
        @(posedge clk);
        #1;
        if (check_en) begin
            in_shift = m_busy && (m_t >= 2) && (m_t <= W + 1);
            ex = in_shift ? m_a[W + 1 - m_t] : 1'b0;
            ey = in_shift ? m_b[W + 1 - m_t] : 1'b0;
            exp = {!m_busy, !m_busy || (m_t == 1), ex, ey, m_busy && (m_t == W + 3),
                   m_g, m_l, m_e, m_c};
            check("cycle_outputs", 32'(dut_vec()), 32'(exp));
        end
        if (rr_rand) bus.result_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, output int acc);
        int n = 0;
        while (!bus.start_ready && n < 100) begin
            step();
            n++;
        end
        check("start_ready_wait", 32'(bus.start_ready), 32'd1);
        bus.start_valid = 1'b1;
        bus.a = av;
        bus.b = bv;
        step();
        acc = cyc;
        bus.start_valid = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
    endtask

    // Full transaction with result_ready high; exp_f = {greater, less, equal, conflict}.
    task automatic directed(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic [3:0] exp_f, input string tag);
        int           acc;
        logic [W-1:0] xs, ys;
        logic         cr_low;
        bus.result_ready = 1'b1;
        send(av, bv, acc);
        check({tag, "_clear_cmp_reset"}, 32'(cmp_reset), 32'd1);
        check({tag, "_clear_start_ready"}, 32'(bus.start_ready), 32'd0);
        cr_low = 1'b1;
        xs = '0;
        ys = '0;
        for (int i = 0; i < W; i++) begin
            step();
            xs = {xs[W-2:0], x_bit};
            ys = {ys[W-2:0], y_bit};
            if (cmp_reset) cr_low = 1'b0;
        end
        check({tag, "_x_sequence"}, 32'(xs), 32'(av));
        check({tag, "_y_sequence"}, 32'(ys), 32'(bv));
        check({tag, "_shift_cmp_reset_low"}, 32'(cr_low), 32'd1);
        step();
        step();
        check({tag, "_result_valid"}, 32'(bus.result_valid), 32'd1);
        // Accept happens in cycle 0, result_valid shows in cycle W+3.
        check({tag, "_latency"}, 32'(cyc - acc), 32'(W + 2));
        check({tag, "_fields"}, 32'({bus.greater, bus.less, bus.equal, bus.conflict}),
              32'(exp_f));
        step();
        check({tag, "_back_idle"}, 32'(bus.start_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int           acc, n, r;
        int           accs[$];
        logic [W-1:0] ra;

        reset = 1'b0;
        fault = 1'b0;
        bus.start_valid  = 1'b0;
        bus.result_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) step();
        check("reset_state", 32'(dut_vec()), 32'(9'b110000000));
        reset = 1'b1;
        step();

        directed(8'hA5, 8'h5A, 4'b1000, "a5_5a");
        directed(8'h3C, 8'h3D, 4'b0100, "lsb_less");
        directed(8'h77, 8'h77, 4'b0010, "equal");

        // Back-pressure: hold result for 5 cycles.
        bus.result_ready = 1'b0;
        send(8'h80, 8'h7F, acc);
        n = 0;
        while (!bus.result_valid && n < 50) begin
            step();
            n++;
        end
        check("bp_latency", 32'(cyc - acc), 32'(W + 2));
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", 32'({bus.result_valid, bus.greater, bus.start_ready}), 32'(3'b110));
            step();
        end
        bus.result_ready = 1'b1;
        step();
        check("bp_release", 32'({bus.start_ready, bus.result_valid, bus.greater}), 32'(3'b101));
        bus.result_ready = 1'b0;

        // Reset during the 4th SHIFT cycle aborts the operation.
        bus.result_ready = 1'b1;
        send(8'h11, 8'h22, acc);
        repeat (4) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("reset_abort", 32'(dut_vec()), 32'(9'b110000000));
        step();
        directed(8'h01, 8'h02, 4'b0100, "after_reset");

        fault = 1'b1;
        directed(8'h12, 8'h34, 4'b1101, "fault");
        fault = 1'b0;

        // Back-to-back with start_valid and result_ready held high.
        bus.result_ready = 1'b1;
        bus.start_valid  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            if (bus.start_ready) accs.push_back(cyc + 1);
            step();
        end
        bus.start_valid = 1'b0;
        check("b2b_accept_count", 32'(accs.size() >= 3), 32'd1);
        for (int i = 1; i < accs.size(); i++) begin
            check("b2b_spacing", 32'(accs[i] - accs[i-1]), 32'd12);
        end
        repeat (15) step();

        // Random traffic with random back-pressure and occasional resets.
        rr_rand = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            bus.start_valid = ($urandom_range(0, 1) != 0);
            ra = W'($urandom);
            r  = $urandom_range(0, 3);
            bus.a = ra;
            if (r == 0) bus.b = ra;
            else if (r == 1) bus.b = ra ^ (W'(1) << $urandom_range(0, W - 1));
            else bus.b = W'($urandom);
            reset = ($urandom_range(0, 299) != 0);
            step();
        end
        rr_rand = 1'b0;
        reset = 1'b1;
        bus.start_valid  = 1'b0;
        bus.result_ready = 1'b1;
        repeat (20) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
